acc_requant_stage: RTL and testbench

- Pipelined requantiser between the MAC array accumulators and the activation blocks (relu/leakyRelu/hardtanh/sigmoid).
- Adds a per-sample bias to the wide signed accumulator, rescales from ACC_FRAC to DECIMAL_POINT fraction bits with round-half-up, and saturates to signed WIDTH.
- Valid/ready on both sides.
- dataOut drives activation `data`; outValid drives activation `enable`.

---
 rtl/acc_requant_stage.sv | 101 ++++++++++
 tb/tb_acc_requant_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_requant_stage.sv
// acc_requant_stage: bias add, round-half-up rescale and saturation of
// MAC accumulators ahead of the activation blocks, valid/ready both sides.
module acc_requant_stage #(
  parameter int ACC_WIDTH     = 24,
  parameter int WIDTH         = 8,
  parameter int DECIMAL_POINT = 4,
  parameter int ACC_FRAC      = 8
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [ACC_WIDTH-1:0] accIn,
  input  logic [ACC_WIDTH-1:0] biasIn,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [WIDTH-1:0]     dataOut,
  output logic                 outValid,
  input  logic                 outReady,
  input  logic                 clearStat,
  output logic [15:0]          satCount
);

  localparam int SHIFT = ACC_FRAC - DECIMAL_POINT;
  localparam int RW    = ACC_WIDTH + 2;

  generate
    if (SHIFT < 1 || SHIFT > ACC_WIDTH - WIDTH) begin : g_bad_shift
      $error("acc_requant_stage: SHIFT out of range");
    end
  endgenerate

  localparam logic signed [RW-1:0] HALF =
    RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV =
    RW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MINV =
    RW'(-(2 ** (WIDTH - 1)));

  logic                        v1;
  logic signed [ACC_WIDTH:0]   sum1;
  logic                        adv2;
  logic signed [RW-1:0]        rnd;
  logic signed [RW-1:0]        r;
  logic                        sat_hi;
  logic                        sat_lo;
  logic                        sat;
  logic [WIDTH-1:0]            q_next;

  assign adv2    = !outValid || outReady;
  assign inReady = iRst && (!v1 || adv2);

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      v1   <= 1'b0;
      sum1 <= '0;
    end else if (inReady) begin
      v1 <= inValid;
      if (inValid) begin
        sum1 <= {accIn[ACC_WIDTH-1], accIn}
              + {biasIn[ACC_WIDTH-1], biasIn};
      end
    end
  end

  // Widen by one more bit so the rounding offset cannot overflow.
  always_comb begin
    rnd    = {sum1[ACC_WIDTH], sum1} + HALF;
    r      = rnd >>> SHIFT;
    sat_hi = r > MAXV;
    sat_lo = r < MINV;
    sat    = sat_hi || sat_lo;
    q_next = r[WIDTH-1:0];
    unique case (1'b1)
      sat_hi:  q_next = MAXV[WIDTH-1:0];
      sat_lo:  q_next = MINV[WIDTH-1:0];
      default: q_next = r[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      outValid <= 1'b0;
      dataOut  <= '0;
    end else if (adv2) begin
      outValid <= v1;
      if (v1) begin
        dataOut <= q_next;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      satCount <= '0;
    end else if (clearStat) begin
      satCount <= '0;
    end else if (adv2 && v1 && sat && satCount != 16'hFFFF) begin
      satCount <= satCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_acc_requant_stage.sv
// tb_acc_requant_stage: scoreboard bench for acc_requant_stage,
// directed cases, backpressure, throughput, saturation and reset.
module tb_acc_requant_stage;

  localparam int AW = 24;
  localparam int W  = 8;
  localparam int SH = 4;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [AW-1:0] accIn;
  logic [AW-1:0] biasIn;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  dataOut;
  logic          outValid;
  logic          outReady;
  logic          clearStat;
  logic [15:0]   satCount;

  acc_requant_stage dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .accIn     (accIn),
    .biasIn    (biasIn),
    .inValid   (inValid),
    .inReady   (inReady),
    .dataOut   (dataOut),
    .outValid  (outValid),
    .outReady  (outReady),
    .clearStat (clearStat),
    .satCount  (satCount)
  );

  always #5 iClk = ~iClk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out   = 0;
  int            stalls  = 0;
  logic [W-1:0]  sb_q[$];
  logic [15:0]   exp_sat = 16'd0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, floor((s + half) / 2^SH), clamp.
  function automatic logic [W-1:0] mdl(input logic [AW-1:0] a,
                                       input logic [AW-1:0] b,
                                       output bit sat);
    longint s, t, q, d;
    d = longint'(1) << SH;
    s = longint'($signed(a)) + longint'($signed(b));
    t = s + d / 2;
    q = t / d;
    if (t < 0 && (t % d) != 0) q = q - 1;
    sat = 1'b0;
    if (q > 127) begin
      q = 127;
      sat = 1'b1;
    end else if (q < -128) begin
      q = -128;
      sat = 1'b1;
    end
    return W'(q);
  endfunction

  always @(negedge iClk) begin
    if (iRst && outValid && outReady) begin
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_data", 32'(dataOut), 32'(sb_q.pop_front()));
      n_out++;
    end
  end

  task automatic push_exp(input logic [AW-1:0] a,
                          input logic [AW-1:0] b);
    bit s;
    logic [W-1:0] e;
    e = mdl(a, b, s);
    sb_q.push_back(e);
    if (s && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [AW-1:0] a,
                      input logic [AW-1:0] b);
    bit done;
    done    = 1'b0;
    accIn   = a;
    biasIn  = b;
    inValid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge iClk);
      if (inReady) begin
        push_exp(a, b);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge iClk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge iClk);
      #1;
    end
    chk("drain", 32'(sb_q.size()), 0);
  endtask

  logic [AW-1:0] ra, rb;
  logic signed [12:0] r13;
  logic signed [9:0]  r10;
  int out0;
  bit  sdummy;

  initial begin
    iRst = 1'b0; accIn = '0; biasIn = '0; inValid = 1'b0;
    outReady = 1'b1; clearStat = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_dataOut", 32'(dataOut), 0);
    chk("rst_satCount", 32'(satCount), 0);
    chk("rst_inReady", 32'(inReady), 0);
    iRst = 1'b1;
    @(posedge iClk);
    #1;

    // Positive rounding with 2-cycle latency.
    send(24'h000128, 24'h000010);
    chk("lat_c1_outValid", 32'(outValid), 0);
    @(posedge iClk);
    #1;
    chk("lat_c2_outValid", 32'(outValid), 1);
    chk("pos_round", 32'(dataOut), 32'h14);
    drain();
    chk("pos_satCount", 32'(satCount), 0);

    // Negative half and near-zero.
    send(24'hFFFEC8, 24'h0);
    send(24'hFFFFF8, 24'h0);
    drain();
    chk("neg_zero", 32'(dataOut), 32'h00);

    // Saturation both ways.
    send(24'h010000, 24'h0);
    drain();
    chk("sat_hi", 32'(dataOut), 32'h7F);
    send(24'hFF0000, 24'h0);
    drain();
    chk("sat_lo", 32'(dataOut), 32'h80);
    chk("sat_count2", 32'(satCount), 32'(exp_sat));
    chk("sat_count2_abs", 32'(satCount), 2);

    // Clear wins over the increment of a simultaneously loaded sat sample.
    send(24'h7FFFFF, 24'h7FFFFF);
    clearStat = 1'b1;
    @(posedge iClk);
    #1;
    clearStat = 1'b0;
    exp_sat = 16'd0;
    drain();
    chk("clear_prio", 32'(satCount), 0);

    // Backpressure: A, B accepted, C held off for 5 cycles.
    outReady = 1'b0;
    send(24'h000128, 24'h000010);
    send(24'h000050, 24'h0);
    accIn = 24'hFFFF00; biasIn = 24'h0; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      chk("bp_inReady", 32'(inReady), 0);
      chk("bp_outValid", 32'(outValid), 1);
      chk("bp_hold", 32'(dataOut), 32'h14);
      @(posedge iClk);
      #1;
    end
    outReady = 1'b1;
    @(negedge iClk);
    chk("bp_rel_inReady", 32'(inReady), 1);
    chk("bp_outA", 32'(outValid), 1);
    if (inReady) push_exp(24'hFFFF00, 24'h0);
    @(posedge iClk);
    #1;
    inValid = 1'b0;
    @(negedge iClk);
    chk("bp_outB", 32'(outValid), 1);
    @(negedge iClk);
    chk("bp_outC", 32'(outValid), 1);
    chk("bp_C_val", 32'(dataOut), 32'hF0);
    @(posedge iClk);
    #1;
    drain();

    // Throughput with random data.
    stalls = 0;
    out0 = n_out;
    for (int i = 0; i < 100; i++) begin
      r13 = 13'($urandom);
      r10 = 10'($urandom);
      ra = AW'(r13);
      rb = AW'(r10);
      send(ra, rb);
    end
    drain();
    chk("tput_stalls", 32'(stalls), 0);
    chk("tput_outs", 32'(n_out - out0), 100);
    chk("tput_satCount", 32'(satCount), 32'(exp_sat));

    // Drive satCount to its ceiling.
    for (int i = 0; i < 65540; i++) begin
      send(24'h400000, 24'h0);
    end
    drain();
    chk("sat_ceiling", 32'(satCount), 32'hFFFF);
    chk("sat_ceiling_mdl", 32'(exp_sat), 32'hFFFF);

    // Reset mid-stream with both stages full.
    outReady = 1'b0;
    send(24'h400000, 24'h0);
    send(24'h000128, 24'h000010);
    iRst = 1'b0;
    @(negedge iClk);
    chk("mrst_inReady", 32'(inReady), 0);
    sb_q.delete();
    exp_sat = 16'd0;
    @(posedge iClk);
    #1;
    chk("mrst_outValid", 32'(outValid), 0);
    chk("mrst_satCount", 32'(satCount), 0);
    iRst = 1'b1;
    outReady = 1'b1;
    send(24'hFFFEC8, 24'h0);
    chk("mrst_c1", 32'(outValid), 0);
    @(posedge iClk);
    #1;
    chk("mrst_c2", 32'(outValid), 1);
    chk("mrst_val", 32'(dataOut), 32'(mdl(24'hFFFEC8, 24'h0, sdummy)));
    drain();
    chk("mrst_val_abs", 32'(dataOut), 32'hED);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
